multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Multicycle successor to the single-cycle MIPS main decoder.
- Moore FSM sequencing fetch, decode, execute, memory and writeback over several cycles, with a shared memory port and a mem_ready handshake.
- Wait-state timeout raises a bus error.
- Sits between the IR opcode field and the multicycle datapath muxes, register file and memory.

Parameters:
- WAIT_LIMIT, 15: max consecutive wait cycles in a memory state before abort; 0 disables timeout.
- CNT_W, 4: wait counter width; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from the cycle after FETCH completes
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- pc_write_ncond  out  1  PC load if ALU not zero (bne)
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch instruction register
- reg_dst  out  2  00=rt, 01=rd, 10=r31
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2
- alu_op  out  3  000 add, 010 sub/compare, 100 and, 101 or, 110 slt, 111 R-type funct
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- state  out  4  current state encoding
- instr_done  out  1  pulse on the final cycle of each instruction
- bus_err  out  1  one-cycle pulse on memory timeout
- trap  out  1  illegal-opcode halt (see Optional Feature)

Behaviour:
- Opcodes:
  - rtype 000000, j 000010, jal 000011, beq 000100, bne 000101
  - addi 001000, slti 001010, andi 001100, ori 001101
  - lw 100011, sw 101011
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11, JAL 12, TRAP 13.
- Reset:
  - State goes to FETCH asynchronously; wait counter is cleared.
  - While rst_n=0, every output is 0 except state=0.
- Unlisted outputs are 0 in each state.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - On mem_ready, go to DECODE; otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000. Next state by opcode:
  - lw/sw -> MEMADR
  - rtype -> RTEXEC
  - beq/bne -> BRANCH
  - addi/slti/andi/ori -> IMMEXEC
  - j -> JUMP
  - jal -> JAL
  - other -> FETCH with instr_done=1 (NOP)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1; on mem_ready go to MEMWB, else hold.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1; go to FETCH.
- MEMWR: mem_write=1, iord=1; on mem_ready assert instr_done and go to FETCH, else hold.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=111; go to ALUWB.
- ALUWB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=010, pc_source=01, pc_write_cond=(opcode==beq), pc_write_ncond=(opcode==bne), instr_done=1; go to FETCH.
- IMMEXEC: alu_src_a=1, alu_src_b=10; alu_op is addi 000, andi 100, ori 101, slti 110; go to IMMWB.
- IMMWB: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1; go to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1; go to FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1; go to FETCH.
- Zero-wait latency (cycles including FETCH):
  - branch/j/jal: 3
  - rtype/imm/sw: 4
  - lw: 5
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle in those states with mem_ready=0.
  - If the counter equals WAIT_LIMIT (WAIT_LIMIT>0) and mem_ready=0: bus_err=1 for that cycle, next state FETCH, counter cleared, no register or IR write.
  - mem_ready wins over timeout in the same cycle.
- Reset mid-instruction aborts immediately; no partial writes after rst_n falls.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Unlisted opcode in DECODE -> TRAP.
  - TRAP: trap=1 and all write/request outputs 0.
  - TRAP is held until reset; instr_done is not asserted.
- Undefined:
  - No TRAP state; unlisted opcodes are NOPs (DECODE -> FETCH, instr_done=1).
  - trap is tied 0.

Test Plan:
- Reset asserted in MEMRD, mem_ready=1 -> outputs all 0 immediately; after release state=0, mem_read=1.
- lw (100011), mem_ready=1 always -> states 0,1,2,3,4; MEMWB shows reg_write=1, mem_to_reg=01, reg_dst=00; instr_done only on cycle 5.
- FETCH with mem_ready low 3 cycles then high -> ir_write=pc_write=1 only on cycle 4; then DECODE.
- WAIT_LIMIT=2, sw with mem_ready stuck 0 in MEMWR -> bus_err pulse on 3rd MEMWR cycle, next state FETCH, mem_write never asserted with mem_ready=1.
- bne (000101) -> BRANCH: pc_write_ncond=1, pc_write_cond=0, alu_op=010, pc_source=01; jal -> JAL: reg_dst=10, mem_to_reg=10, pc_write=1.
- Opcode 111111 -> with ILLEGAL_TRAP_EN, state=13 and trap=1 for 20 cycles; without it, DECODE->FETCH with instr_done=1.

Source files
------------

// File: rtl/multicycle_main_control.sv
// ---------------------------------------------------------------------------
// multicycle_main_control
//
// Main control unit for a multicycle MIPS datapath. A Moore FSM steps each
// instruction through FETCH / DECODE / execute / memory / writeback states,
// sharing one memory port that is gated by a mem_ready handshake. A wait
// counter bounds the number of consecutive stalled cycles in a memory state;
// running out of wait budget raises a one-cycle bus_err and returns to FETCH.
//
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   : an unlisted opcode in DECODE enters TRAP, which holds until
//               reset and asserts trap.
//   undefined : unlisted opcodes are executed as NOPs; trap is tied low.
//
// Parameters:
//   WAIT_LIMIT  max consecutive wait cycles in a memory state (0 = no timeout)
//   CNT_W       wait counter width, 2**CNT_W must exceed WAIT_LIMIT
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   opcode             IR[31:26], valid from the cycle after FETCH completes
//   mem_ready          memory completes the current access this cycle
//   pc_write           unconditional PC load
//   pc_write_cond      PC load if ALU zero (beq)
//   pc_write_ncond     PC load if ALU not zero (bne)
//   iord               memory address select: 0=PC, 1=ALUOut
//   mem_read/mem_write memory requests
//   ir_write           instruction register load
//   reg_dst            00=rt, 01=rd, 10=r31
//   mem_to_reg         00=ALUOut, 01=MDR, 10=PC
//   reg_write          register file write
//   alu_src_a          0=PC, 1=A
//   alu_src_b          00=B, 01=4, 10=sign-ext imm, 11=imm<<2
//   alu_op             000 add, 010 sub, 100 and, 101 or, 110 slt, 111 funct
//   pc_source          00=ALU, 01=ALUOut, 10=jump target
//   state              current state encoding
//   instr_done         pulse on the final cycle of each instruction
//   bus_err            one-cycle pulse on memory timeout
//   trap               illegal-opcode halt indicator
// ---------------------------------------------------------------------------
module multicycle_main_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_ncond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       bus_err,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam bit               LIMIT_EN = (WAIT_LIMIT > 0);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_st;
    logic             timeout;

    // Raw (un-gated) control values from the next-state process
    logic       r_pc_write, r_pc_write_cond, r_pc_write_ncond;
    logic       r_iord, r_mem_read, r_mem_write, r_ir_write;
    logic [1:0] r_reg_dst, r_mem_to_reg;
    logic       r_reg_write, r_alu_src_a;
    logic [1:0] r_alu_src_b;
    logic [2:0] r_alu_op;
    logic [1:0] r_pc_source;
    logic       r_instr_done, r_bus_err;
`ifdef ILLEGAL_TRAP_EN
    logic       r_trap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = '0;
        r_pc_write       = 1'b0;
        r_pc_write_cond  = 1'b0;
        r_pc_write_ncond = 1'b0;
        r_iord           = 1'b0;
        r_mem_read       = 1'b0;
        r_mem_write      = 1'b0;
        r_ir_write       = 1'b0;
        r_reg_dst        = 2'b00;
        r_mem_to_reg     = 2'b00;
        r_reg_write      = 1'b0;
        r_alu_src_a      = 1'b0;
        r_alu_src_b      = 2'b00;
        r_alu_op         = 3'b000;
        r_pc_source      = 2'b00;
        r_instr_done     = 1'b0;
        r_bus_err        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        r_trap           = 1'b0;
`endif

        wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        // mem_ready takes priority: a completing access is never a timeout
        timeout = LIMIT_EN && wait_st && !mem_ready && (cnt_q == LIMIT);

        case (state_q)
            S_FETCH: begin
                r_mem_read  = 1'b1;
                r_alu_src_b = 2'b01;
                r_ir_write  = mem_ready;
                r_pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                r_alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = S_RTEXEC;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMMEXEC;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d      = S_FETCH;
                        r_instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                r_alu_src_a = 1'b1;
                r_alu_src_b = 2'b10;
                state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                r_mem_read = 1'b1;
                r_iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                r_reg_write  = 1'b1;
                r_mem_to_reg = 2'b01;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                r_mem_write = 1'b1;
                r_iord      = 1'b1;
                if (mem_ready) begin
                    r_instr_done = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_RTEXEC: begin
                r_alu_src_a = 1'b1;
                r_alu_op    = 3'b111;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                r_reg_write  = 1'b1;
                r_reg_dst    = 2'b01;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                r_alu_src_a      = 1'b1;
                r_alu_op         = 3'b010;
                r_pc_source      = 2'b01;
                r_pc_write_cond  = (opcode == OP_BEQ);
                r_pc_write_ncond = (opcode == OP_BNE);
                r_instr_done     = 1'b1;
                state_d          = S_FETCH;
            end
            S_IMMEXEC: begin
                r_alu_src_a = 1'b1;
                r_alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: r_alu_op = 3'b100;
                    OP_ORI:  r_alu_op = 3'b101;
                    OP_SLTI: r_alu_op = 3'b110;
                    default: r_alu_op = 3'b000;
                endcase
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                r_reg_write  = 1'b1;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                r_pc_write   = 1'b1;
                r_pc_source  = 2'b10;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                r_pc_write   = 1'b1;
                r_pc_source  = 2'b10;
                r_reg_write  = 1'b1;
                r_reg_dst    = 2'b10;
                r_mem_to_reg = 2'b10;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                r_trap  = 1'b1;
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // Wait accounting: every non-stalled cycle leaves the counter at zero,
        // which is what clears it on entry to the next memory state.
        if (wait_st && !mem_ready) begin
            if (timeout) begin
                r_bus_err = 1'b1;
                state_d   = S_FETCH;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // All controls are forced low while reset is held, so a reset in the
    // middle of an instruction cannot leak a write or a memory request.
    assign pc_write       = rst_n & r_pc_write;
    assign pc_write_cond  = rst_n & r_pc_write_cond;
    assign pc_write_ncond = rst_n & r_pc_write_ncond;
    assign iord           = rst_n & r_iord;
    assign mem_read       = rst_n & r_mem_read;
    assign mem_write      = rst_n & r_mem_write;
    assign ir_write       = rst_n & r_ir_write;
    assign reg_dst        = {2{rst_n}} & r_reg_dst;
    assign mem_to_reg     = {2{rst_n}} & r_mem_to_reg;
    assign reg_write      = rst_n & r_reg_write;
    assign alu_src_a      = rst_n & r_alu_src_a;
    assign alu_src_b      = {2{rst_n}} & r_alu_src_b;
    assign alu_op         = {3{rst_n}} & r_alu_op;
    assign pc_source      = {2{rst_n}} & r_pc_source;
    assign instr_done     = rst_n & r_instr_done;
    assign bus_err        = rst_n & r_bus_err;
    assign state          = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign trap           = rst_n & r_trap;
`else
    assign trap           = 1'b0;
`endif

endmodule
